// File: rtl/run_event_logger.sv
// Run event logger: counts detector run events into BCD display counters,
// with a stretched LED pulse, last-kind flag and sticky error flag.
module run_event_logger #(
  parameter int         DIGITS  = 2,
  parameter bit         WRAP    = 1'b0,
  parameter int         STRETCH = 8,
  parameter logic [8:0] Y_ZERO  = 9'd4,
  parameter logic [8:0] Y_ONE   = 9'd8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              z,
  input  logic [8:0]        y,
  input  logic              clr,
  output logic [4*DIGITS-1:0] cnt_zero,
  output logic [4*DIGITS-1:0] cnt_one,
  output logic              last_one,
  output logic              led,
  output logic              sat,
  output logic              err
);

  localparam int W  = 4 * DIGITS;
  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [W-1:0]  ALL9  = {DIGITS{4'h9}};
  localparam logic [SW-1:0] ST_LD = SW'(STRETCH);

  logic          z_q;
  logic [W-1:0]  cz_q, cz_d;
  logic [W-1:0]  co_q, co_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [SW-1:0] st_q, st_d;
  logic          rise;

  // Ripple BCD increment; all-9s either holds or rolls to zero.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    if (!WRAP && v == ALL9) r = v;
    return r;
  endfunction

  assign rise = z & ~z_q;

  always_comb begin
    cz_d   = cz_q;
    co_d   = co_q;
    last_d = last_q;
    err_d  = err_q;
    st_d   = (st_q != '0) ? st_q - SW'(1) : st_q;
    priority case (1'b1)
      clr: begin
        cz_d   = '0;
        co_d   = '0;
        last_d = 1'b0;
        err_d  = 1'b0;
        st_d   = '0;
      end
      rise: begin
        st_d = ST_LD;
        if (y == Y_ZERO) begin
          cz_d   = bcd_inc(cz_q);
          last_d = 1'b0;
        end else if (y == Y_ONE) begin
          co_d   = bcd_inc(co_q);
          last_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q    <= 1'b0;
      cz_q   <= '0;
      co_q   <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      st_q   <= '0;
    end else begin
      z_q    <= z;
      cz_q   <= cz_d;
      co_q   <= co_d;
      last_q <= last_d;
      err_q  <= err_d;
      st_q   <= st_d;
    end
  end

  assign cnt_zero = cz_q;
  assign cnt_one  = co_q;
  assign last_one = last_q;
  assign err      = err_q;
  assign led      = (st_q != '0);
  assign sat      = !WRAP && (cz_q == ALL9 || co_q == ALL9);

endmodule

// File: tb/tb_run_event_logger.sv
// Bench for run_event_logger: saturating and wrapping instances share one
// stimulus stream and are checked against an event-count reference model.
module tb_run_event_logger;

  localparam int ST = 8;

  logic       clk = 1'b0;
  logic       reset, z, clr;
  logic [8:0] y;
  logic [7:0] cz0, co0, cz1, co1;
  logic       l0, l1, led0, led1, s0, s1, e0, e1;

  always #5 clk = ~clk;

  run_event_logger #(.WRAP(1'b0)) u0 (
    .clk(clk), .reset(reset), .z(z), .y(y), .clr(clr),
    .cnt_zero(cz0), .cnt_one(co0), .last_one(l0),
    .led(led0), .sat(s0), .err(e0)
  );

  run_event_logger #(.WRAP(1'b1)) u1 (
    .clk(clk), .reset(reset), .z(z), .y(y), .clr(clr),
    .cnt_zero(cz1), .cnt_one(co1), .last_one(l1),
    .led(led1), .sat(s1), .err(e1)
  );

  int vec = 0;
  int bad = 0;
  int n0, n1, cyc, lr;
  bit mzd, mlast, merr;

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) % 10) * 16 + (n % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mclear();
    n0    = 0;
    n1    = 0;
    mlast = 1'b0;
    merr  = 1'b0;
    lr    = -1000;
  endtask

  task automatic check_all();
    logic [7:0] ez0, eo0, ez1, eo1;
    logic       eled, esat;
    ez0  = bcd(n0 > 99 ? 99 : n0);
    eo0  = bcd(n1 > 99 ? 99 : n1);
    ez1  = bcd(n0 % 100);
    eo1  = bcd(n1 % 100);
    eled = (cyc - lr) < ST;
    esat = (n0 >= 99) || (n1 >= 99);
    chk("cnt_zero_sat", cz0, ez0);
    chk("cnt_one_sat", co0, eo0);
    chk("cnt_zero_wrap", cz1, ez1);
    chk("cnt_one_wrap", co1, eo1);
    chk("last_one_sat", 8'(l0), 8'(mlast));
    chk("last_one_wrap", 8'(l1), 8'(mlast));
    chk("led_sat", 8'(led0), 8'(eled));
    chk("led_wrap", 8'(led1), 8'(eled));
    chk("sat_sat", 8'(s0), 8'(esat));
    chk("sat_wrap", 8'(s1), 8'd0);
    chk("err_sat", 8'(e0), 8'(merr));
    chk("err_wrap", 8'(e1), 8'(merr));
  endtask

  task automatic cyc1(input bit zi, input logic [8:0] yi, input bit ci);
    bit rise;
    z   = zi;
    y   = yi;
    clr = ci;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      mclear();
      mzd = 1'b0;
    end else begin
      rise = zi && !mzd;
      mzd  = zi;
      if (ci) begin
        mclear();
      end else if (rise) begin
        lr = cyc;
        if (yi == 9'd4) begin
          n0++;
          mlast = 1'b0;
        end else if (yi == 9'd8) begin
          n1++;
          mlast = 1'b1;
        end else begin
          merr = 1'b1;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    mclear();
    mzd = 1'b0;
    check_all();
  endtask

  initial begin
    z = 1'b0; y = '0; clr = 1'b0; cyc = 0;
    do_reset();
    cyc1(0, 0, 0);
    reset = 1'b1;
    cyc1(0, 0, 0);
    // single zero run held for three cycles, then let the pulse expire
    repeat (3) cyc1(1, 9'd4, 0);
    repeat (10) cyc1(0, 9'd4, 0);
    // ten one-runs crossing the first BCD carry
    repeat (10) begin
      repeat (2) cyc1(1, 9'd8, 0);
      repeat (3) cyc1(0, 9'd8, 0);
    end
    // 100 zero runs: saturate vs wrap
    cyc1(0, 0, 1);
    repeat (100) begin
      cyc1(1, 9'd4, 0);
      cyc1(0, 9'd4, 0);
    end
    repeat (3) cyc1(0, 0, 0);
    // unclassifiable event then clear
    cyc1(1, 9'd3, 0);
    cyc1(0, 9'd3, 0);
    cyc1(0, 0, 1);
    cyc1(0, 0, 0);
    // clear collides with a rise; z held afterwards
    cyc1(1, 9'd8, 1);
    repeat (4) cyc1(1, 9'd8, 0);
    cyc1(0, 0, 0);
    // retriggered stretch, then reset mid-stretch
    repeat (3) begin
      cyc1(1, 9'd8, 0);
      repeat (3) cyc1(0, 9'd8, 0);
    end
    repeat (9) cyc1(0, 0, 0);
    cyc1(1, 9'd4, 0);
    cyc1(0, 0, 0);
    do_reset();
    z = 1'b1;
    cyc1(1, 9'd4, 0);
    reset = 1'b1;
    repeat (3) cyc1(1, 9'd4, 0);
    cyc1(0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] yr;
      int         k;
      k  = $urandom_range(0, 3);
      yr = (k == 0) ? 9'($urandom) : (k == 1) ? 9'd8 : 9'd4;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        cyc1($urandom_range(0, 1) == 1, yr, 0);
        reset = 1'b1;
      end else begin
        cyc1($urandom_range(0, 2) == 0, yr,
             $urandom_range(0, 59) == 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
